mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multicycle MIPS execution core: instruction decode (main control), ALU control,
//  32x32 register file, 128-word data memory and ALU, sequenced by a 4-phase FSM.
//  A host presents one instruction word at a time and pulses newinstr.
//  No PC/fetch; branches are decoded only, never taken.
// PARAMETERS
//  MEM_WORDS  128  data memory depth in 32-bit words (address = byte_addr[8:2])
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high; clears state, regfile, memory
//  instrword     in   32  instruction, sampled when newinstr=1 at clock edge
//  newinstr      in   1   start strobe, synchronous
//  dbg_reg_addr  in   5   debug regfile read address (combinational)
//  dbg_reg_data  out  32  regfile[dbg_reg_addr]
//  dbg_mem_addr  in   7   debug memory word address
//  dbg_mem_data  out  32  memory[dbg_mem_addr]
//  alu_result    out  32  registered ALU result of current instruction
//  zero          out  1   alu_result==0
//  state         out  3   FSM state: ID=0, EX=1, MEM=2, WB=3, DONE=4
//  done          out  1   1 when state==DONE
// BEHAVIOUR
//  Reset: state=DONE, done=1, alu_result=0, IR=0, MDR=0, all 32 regs and all
//   MEM_WORDS memory words = 0. Reset mid-instruction aborts it; no pending write.
//  Priority per edge: reset > newinstr > FSM advance.
//  newinstr=1: IR<=instrword, state<=ID (from any state; restarts the in-flight op).
//  ID -> EX -> MEM -> WB -> DONE, one clock each; DONE holds until newinstr.
//  Completion: done asserted 4 edges after the newinstr edge.
//  Decode (from IR): op 0x00 R-type: RegDst=1,RegWrite=1,ALUOp=10.
//   op 0x23 lw: ALUSrc,MemRead,MemToReg,RegWrite, ALUOp=00.
//   op 0x2B sw: ALUSrc,MemWrite, ALUOp=00.  op 0x08 addi: ALUSrc,RegWrite, ALUOp=00.
//   op 0x04 beq: Branch=1, ALUOp=01 (no other effect). Other opcodes: all controls 0.
//  ALU control: ALUOp 00->add(0010); 01->sub(0110); 10->by funct:
//   0x20 add 0010, 0x22 sub 0110, 0x24 and 0000, 0x25 or 0001, 0x27 nor 1100,
//   0x2A slt 0111; other funct -> 1111 (result 0, RegWrite suppressed).
//  Operands: A=reg[rs]; B=ALUSrc ? signext(imm16) : reg[rt]. 32-bit wrap arithmetic;
//   slt signed: result 1/0.
//  EX: alu_result<=ALU(A,B).  MEM: MemRead -> MDR<=mem[alu_result[8:2]];
//   MemWrite -> mem[alu_result[8:2]]<=reg[rt]. Address bits [31:9],[1:0] ignored (wrap).
//  WB: if RegWrite, reg[RegDst?rd:rt] <= MemToReg?MDR:alu_result. Exactly one write per
//   instruction. Writes to reg 0 discarded; reg 0 always reads 0.
//  Control signals derived from IR, stable for whole instruction.
// TESTING
//  1 Reset after random writes -> all dbg_reg_data and dbg_mem_data = 0, done=1.
//  2 addi $1,$0,5 (0x20010005); addi $2,$0,-3 (0x2002FFFD); add $3,$1,$2
//    (0x00221820) -> reg3=2; sub $4,$2,$1 (0x00412022) -> reg4=0xFFFFFFF8.
//  3 sw $1,8($0) (0xAC010008) -> mem[2]=5; lw $5,8($0) (0x8C050008) -> reg5=5;
//    sw $1,0x208($0) -> mem[2] (wrap).
//  4 slt $6,$2,$1 (0x0041302A) -> reg6=1; addi $0,$0,7 -> reg0 stays 0.
//  5 newinstr in EX of add $3 then addi $7,$0,1 -> reg7=1, reg3 unchanged; done 4 edges later.
//  6 reset asserted in MEM of sw -> memory and regs all 0, state=DONE immediately.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS execution core: decode, ALU control, register file, data memory
// and ALU, stepped through ID/EX/MEM/WB by a small FSM. No fetch; branches never taken.
module mips_multicycle_core #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrword,
  input  logic        newinstr,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data,
  input  logic [6:0]  dbg_mem_addr,
  output logic [31:0] dbg_mem_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [2:0]  state,
  output logic        done
);

  localparam int MEM_AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef enum logic [2:0] {
    ST_ID   = 3'd0,
    ST_EX   = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0] ir, mdr;
  logic [31:0] regs [32];
  logic [31:0] mem [MEM_WORDS];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic [15:0] imm;
  logic        reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a, op_b, alu_out, wb_data;
  logic        reg_write_eff;
  logic [MEM_AW-1:0] mem_idx;
  logic        unused_ok;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign imm     = ir[15:0];
  assign funct   = ir[5:0];
  assign mem_idx = alu_result[MEM_AW+1:2];

  // Main control: everything derives from IR, so it stays stable for the whole op.
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    case (opcode)
      OP_RTYPE: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; end
      OP_LW:    begin alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_SW:    begin alu_src = 1'b1; mem_write = 1'b1; end
      OP_ADDI:  begin alu_src = 1'b1; reg_write = 1'b1; end
      OP_BEQ:   begin branch = 1'b1; alu_op = 2'b01; end
      default:  ;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (funct)
          6'h20:   alu_ctl = ALU_ADD;
          6'h22:   alu_ctl = ALU_SUB;
          6'h24:   alu_ctl = ALU_AND;
          6'h25:   alu_ctl = ALU_OR;
          6'h27:   alu_ctl = ALU_NOR;
          6'h2A:   alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_BAD;
        endcase
      end
    endcase
  end

  assign op_a = regs[rs];
  assign op_b = alu_src ? {{16{imm[15]}}, imm} : regs[rt];

  always_comb begin
    alu_out = 32'd0;
    case (alu_ctl)
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_AND: alu_out = op_a & op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_NOR: alu_out = ~(op_a | op_b);
      ALU_SLT: alu_out = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_out = 32'd0;
    endcase
  end

  // An unsupported funct must not write back even though it is R-type.
  assign reg_write_eff = reg_write && (alu_ctl != ALU_BAD);
  assign wb_addr       = reg_dst ? rd : rt;
  assign wb_data       = mem_to_reg ? mdr : alu_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_DONE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (newinstr) begin
      state_d = ST_ID;
    end else begin
      case (state_q)
        ST_ID:   state_d = ST_EX;
        ST_EX:   state_d = ST_MEM;
        ST_MEM:  state_d = ST_WB;
        ST_WB:   state_d = ST_DONE;
        default: state_d = ST_DONE;
      endcase
    end
  end

  // A new strobe pre-empts whatever phase action the aborted op would have taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir         <= 32'd0;
      mdr        <= 32'd0;
      alu_result <= 32'd0;
    end else if (newinstr) begin
      ir <= instrword;
    end else begin
      if (state_q == ST_EX)              alu_result <= alu_out;
      if (state_q == ST_MEM && mem_read) mdr        <= mem[mem_idx];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (!newinstr && state_q == ST_WB && reg_write_eff && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (!newinstr && state_q == ST_MEM && mem_write) begin
      mem[mem_idx] <= regs[rt];
    end
  end

  assign dbg_reg_data = regs[dbg_reg_addr];
  assign dbg_mem_data = mem[dbg_mem_addr];
  assign zero         = (alu_result == 32'd0);
  assign state        = state_q;
  assign done         = (state_q == ST_DONE);

  assign unused_ok = &{1'b0, branch, ir[10:6], alu_result[31:MEM_AW+2], alu_result[1:0]};

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: expected register/memory/ALU values
// are queued as each instruction is issued and compared once it completes.
module tb_mips_multicycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrword = 32'd0;
  logic        newinstr = 1'b0;
  logic [4:0]  dbg_reg_addr = 5'd0;
  logic [31:0] dbg_reg_data;
  logic [6:0]  dbg_mem_addr = 7'd0;
  logic [31:0] dbg_mem_data;
  logic [31:0] alu_result;
  logic        zero;
  logic [2:0]  state;
  logic        done;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    string       tag;
    int          kind;
    int          addr;
    logic [31:0] value;
  } expect_t;

  expect_t scoreboard[$];

  mips_multicycle_core #(.MEM_WORDS(128)) dut (
    .clock(clock), .reset(reset), .instrword(instrword), .newinstr(newinstr),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
    .alu_result(alu_result), .zero(zero), .state(state), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // kind: 0 = register, 1 = memory word, 2 = alu_result
  task automatic pushExpect(input string tag, input int kind, input int addr, input logic [31:0] value);
    expect_t e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic drainScoreboard();
    expect_t e;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      if (e.kind == 0) begin
        dbg_reg_addr = e.addr[4:0]; #1;
        checkOutput(e.tag, dbg_reg_data, e.value);
      end else if (e.kind == 1) begin
        dbg_mem_addr = e.addr[6:0]; #1;
        checkOutput(e.tag, dbg_mem_data, e.value);
      end else begin
        checkOutput(e.tag, alu_result, e.value);
      end
    end
  endtask

  task automatic issueInstr(input logic [31:0] instr);
    @(negedge clock);
    instrword = instr;
    newinstr  = 1'b1;
    @(posedge clock); #1;
    newinstr  = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int edges = 0;
    while (done !== 1'b1 && edges < 12) begin
      @(posedge clock); #1;
      edges++;
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_latency"}, edges, 32'd4);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] instr);
    issueInstr(instr);
    waitDone(tag);
    drainScoreboard();
  endtask

  task automatic checkAllZero(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_reg_addr = r[4:0]; #1;
      checkOutput({tag, "_reg"}, dbg_reg_data, 32'd0);
    end
    for (int m = 0; m < 128; m++) begin
      dbg_mem_addr = m[6:0]; #1;
      checkOutput({tag, "_mem"}, dbg_mem_data, 32'd0);
    end
  endtask

  initial begin
    logic [4:0]  rnd_reg;
    logic [15:0] rnd_imm;
    logic [6:0]  rnd_word;

    $display("[TB] starting");
    #12;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_state", {29'd0, state}, 32'd4);
    checkOutput("reset_alu", alu_result, 32'd0);
    checkOutput("reset_zero", {31'd0, zero}, 32'd1);

    // Scatter random writes, then reset must wipe them all.
    for (int k = 0; k < 6; k++) begin
      rnd_reg  = 5'($urandom_range(1, 31));
      rnd_imm  = 16'($urandom);
      rnd_word = 7'($urandom_range(0, 127));
      applyStimulus("rand_addi", {6'h08, 5'd0, rnd_reg, rnd_imm});
      applyStimulus("rand_sw", {6'h2B, 5'd0, rnd_reg, 7'd0, rnd_word, 2'b00});
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    checkOutput("t1_done", {31'd0, done}, 32'd1);
    checkAllZero("t1");

    pushExpect("addi_r1", 0, 1, 32'd5);
    applyStimulus("addi1", 32'h20010005);
    pushExpect("addi_r2", 0, 2, 32'hFFFFFFFD);
    applyStimulus("addi2", 32'h2002FFFD);
    pushExpect("add_r3", 0, 3, 32'd2);
    pushExpect("add_alu", 2, 0, 32'd2);
    applyStimulus("add", 32'h00221820);
    pushExpect("sub_r4", 0, 4, 32'hFFFFFFF8);
    applyStimulus("sub", 32'h00412022);

    pushExpect("sw_mem2", 1, 2, 32'd5);
    applyStimulus("sw", 32'hAC010008);
    pushExpect("lw_r5", 0, 5, 32'd5);
    applyStimulus("lw", 32'h8C050008);
    pushExpect("sw_wrap_mem2", 1, 2, 32'hFFFFFFFD);
    pushExpect("sw_wrap_alu", 2, 0, 32'h00000208);
    applyStimulus("sw_wrap", 32'hAC020208);

    pushExpect("slt_r6", 0, 6, 32'd1);
    applyStimulus("slt", 32'h0041302A);
    pushExpect("addi_r0", 0, 0, 32'd0);
    pushExpect("addi_r0_alu", 2, 0, 32'd7);
    applyStimulus("addi_r0", 32'h20000007);
    pushExpect("badfunct_r8", 0, 8, 32'd0);
    pushExpect("badfunct_alu", 2, 0, 32'd0);
    applyStimulus("badfunct", 32'h0022403F);
    pushExpect("beq_alu", 2, 0, 32'd8);
    pushExpect("beq_r2", 0, 2, 32'hFFFFFFFD);
    applyStimulus("beq", 32'h10220000);

    // Restart add $3,$1,$1 while it sits in EX; $3 must keep its old value.
    issueInstr(32'h00211820);
    @(posedge clock); #1;
    checkOutput("t5_in_ex", {29'd0, state}, 32'd1);
    issueInstr(32'h20070001);
    waitDone("restart");
    pushExpect("restart_r7", 0, 7, 32'd1);
    pushExpect("restart_r3", 0, 3, 32'd2);
    drainScoreboard();

    // Reset during MEM of sw must abort the store.
    issueInstr(32'hAC01000C);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("t6_in_mem", {29'd0, state}, 32'd2);
    reset = 1'b1; #1;
    checkOutput("t6_state", {29'd0, state}, 32'd4);
    checkOutput("t6_done", {31'd0, done}, 32'd1);
    @(negedge clock); reset = 1'b0;
    checkAllZero("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
